// File: rtl/trade_order_executor.sv
`default_nettype none
// ============================================================================
// Module   : trade_order_executor
// Brief    : Turns per-tick buy/sell indications into discrete orders, enforces
//            per-stock position limits and cooldown, buffers orders in a small
//            FIFO and issues them over a valid/ready handshake.
//            Optional macro TRADE_STATS_EN adds handshaken buy/sell counters.
// Revision : 1.0 - initial release
// ============================================================================
module trade_order_executor #(
    parameter int MAX_POS    = 15,
    parameter int FIFO_DEPTH = 4,
    parameter int COOLDOWN   = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sig_valid,
    input  logic        buy_signal,
    input  logic        sell_signal,
    input  logic [1:0]  stock_id_in,
    output logic        order_valid,
    input  logic        order_ready,
    output logic        order_side,
    output logic [1:0]  order_stock_id,
    output logic [15:0] positions,
    output logic        fifo_full,
    output logic [7:0]  drop_count,
`ifdef TRADE_STATS_EN
    output logic [15:0] buy_count,
    output logic [15:0] sell_count,
`endif
    output logic [7:0]  conflict_count
);

    localparam int c_AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_CW  = c_AW + 1;
    localparam int c_CDW = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
    localparam logic [c_CW-1:0]  c_DEPTH   = c_CW'(FIFO_DEPTH);
    localparam logic [c_CDW-1:0] c_CD_LOAD = c_CDW'(COOLDOWN);
    localparam logic [3:0]       c_MAX     = 4'(MAX_POS);

    logic [3:0]      r_pos   [4];
    logic [c_CDW-1:0] r_cd   [4];
    logic [2:0]      r_mem   [FIFO_DEPTH];   // {side, stock_id}
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_CW-1:0] r_count;
    logic            r_full;
    logic [7:0]      r_drop;
    logic [7:0]      r_conflict;

    logic            w_valid;
    logic            w_pop;
    logic [3:0]      w_pos_sel;
    logic [c_CDW-1:0] w_cd_sel;
    logic            w_buy_cand;
    logic            w_sell_cand;
    logic            w_cand;
    logic            w_push;
    logic            w_drop;
    logic            w_conflict;
    logic [c_CW-1:0] w_count_nxt;

    assign w_valid   = (r_count != '0);
    assign w_pop     = w_valid && order_ready;
    assign w_pos_sel = r_pos[stock_id_in];
    assign w_cd_sel  = r_cd[stock_id_in];

    // A lone buy or sell becomes a candidate only if the limit and cooldown allow it
    assign w_buy_cand  = sig_valid && buy_signal && !sell_signal &&
                         (w_pos_sel < c_MAX) && (w_cd_sel == '0);
    assign w_sell_cand = sig_valid && sell_signal && !buy_signal &&
                         (w_pos_sel != 4'd0) && (w_cd_sel == '0);
    assign w_cand      = w_buy_cand || w_sell_cand;

    // A full FIFO still accepts a push when the head leaves on the same edge
    assign w_push      = w_cand && (!r_full || w_pop);
    assign w_drop      = w_cand && !w_push;
    assign w_conflict  = sig_valid && buy_signal && sell_signal;
    assign w_count_nxt = r_count + c_CW'(w_push) - c_CW'(w_pop);

    // Order FIFO storage, pointers, occupancy and registered full flag
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= 3'd0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= {w_sell_cand, stock_id_in};
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == c_DEPTH);
        end
    end

    // Positions commit at enqueue; cooldown load wins over the per-cycle decrement
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                r_pos[i] <= 4'd0;
                r_cd[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (w_push && (stock_id_in == 2'(i))) begin
                    r_cd[i]  <= c_CD_LOAD;
                    r_pos[i] <= w_sell_cand ? (r_pos[i] - 4'd1) : (r_pos[i] + 4'd1);
                end else if (r_cd[i] != '0) begin
                    r_cd[i] <= r_cd[i] - 1'b1;
                end
            end
        end
    end

    // Saturating drop and conflict counters
    always_ff @(posedge clk) begin
        if (rst) begin
            r_drop     <= 8'd0;
            r_conflict <= 8'd0;
        end else begin
            if (w_drop && (r_drop != 8'hFF)) begin
                r_drop <= r_drop + 8'd1;
            end
            if (w_conflict && (r_conflict != 8'hFF)) begin
                r_conflict <= r_conflict + 8'd1;
            end
        end
    end

`ifdef TRADE_STATS_EN
    logic [15:0] r_buy_count;
    logic [15:0] r_sell_count;

    // Saturating counts of handshaken orders per side
    always_ff @(posedge clk) begin
        if (rst) begin
            r_buy_count  <= 16'd0;
            r_sell_count <= 16'd0;
        end else if (w_pop) begin
            if (!r_mem[r_rd_ptr][2] && (r_buy_count != 16'hFFFF)) begin
                r_buy_count <= r_buy_count + 16'd1;
            end
            if (r_mem[r_rd_ptr][2] && (r_sell_count != 16'hFFFF)) begin
                r_sell_count <= r_sell_count + 16'd1;
            end
        end
    end

    assign buy_count  = r_buy_count;
    assign sell_count = r_sell_count;
`endif

    for (genvar g = 0; g < 4; g++) begin : g_pos
        assign positions[4*g +: 4] = r_pos[g];
    end

    assign order_valid    = w_valid;
    assign order_side     = w_valid && r_mem[r_rd_ptr][2];
    assign order_stock_id = w_valid ? r_mem[r_rd_ptr][1:0] : 2'd0;
    assign fifo_full      = r_full;
    assign drop_count     = r_drop;
    assign conflict_count = r_conflict;

endmodule
`default_nettype wire

// File: tb/tb_trade_order_executor.sv
`default_nettype none
// ============================================================================
// Module   : tb_trade_order_executor
// Brief    : Directed and random stimulus for trade_order_executor, compared
//            against a queue-based reference model of the order flow.
// Revision : 1.0 - initial release
// ============================================================================
module tb_trade_order_executor;

    localparam int MAX_POS = 15;
    localparam int DEPTH   = 4;
    localparam int CD      = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        sig_valid;
    logic        buy_signal;
    logic        sell_signal;
    logic [1:0]  stock_id_in;
    logic        order_valid;
    logic        order_ready;
    logic        order_side;
    logic [1:0]  order_stock_id;
    logic [15:0] positions;
    logic        fifo_full;
    logic [7:0]  drop_count;
    logic [7:0]  conflict_count;
`ifdef TRADE_STATS_EN
    logic [15:0] buy_count;
    logic [15:0] sell_count;
`endif

    trade_order_executor #(
        .MAX_POS    (MAX_POS),
        .FIFO_DEPTH (DEPTH),
        .COOLDOWN   (CD)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .sig_valid      (sig_valid),
        .buy_signal     (buy_signal),
        .sell_signal    (sell_signal),
        .stock_id_in    (stock_id_in),
        .order_valid    (order_valid),
        .order_ready    (order_ready),
        .order_side     (order_side),
        .order_stock_id (order_stock_id),
        .positions      (positions),
        .fifo_full      (fifo_full),
        .drop_count     (drop_count),
`ifdef TRADE_STATS_EN
        .buy_count      (buy_count),
        .sell_count     (sell_count),
`endif
        .conflict_count (conflict_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: orders are queue entries side*4+id; cooldown tracked as
    // the cycle index of the last enqueue per stock.
    int m_pos  [4];
    int m_last [4];
    int m_q    [$];
    int m_drop, m_conf, m_cyc, m_buys, m_sells;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] exp_positions();
        return {4'(m_pos[3]), 4'(m_pos[2]), 4'(m_pos[1]), 4'(m_pos[0])};
    endfunction

    task automatic check_all();
        check("valid", 32'(order_valid), 32'(m_q.size() > 0));
        if (m_q.size() > 0) begin
            check("side",  32'(order_side),     32'(m_q[0] / 4));
            check("stock", 32'(order_stock_id), 32'(m_q[0] % 4));
        end
        check("positions", 32'(positions),      32'(exp_positions()));
        check("full",      32'(fifo_full),      32'(m_q.size() == DEPTH));
        check("drops",     32'(drop_count),     32'(m_drop));
        check("conflicts", 32'(conflict_count), 32'(m_conf));
`ifdef TRADE_STATS_EN
        check("buy_count",  32'(buy_count),  32'(m_buys));
        check("sell_count", 32'(sell_count), 32'(m_sells));
`endif
    endtask

    // One clock cycle: drive inputs, advance the model, then compare after the edge
    task automatic step(input bit r, input bit sv, input bit b, input bit s,
                        input int id, input bit rdy);
        bit pop;
        bit was_full;
        bit cand;
        bit is_sell;
        rst         = r;
        sig_valid   = sv;
        buy_signal  = b;
        sell_signal = s;
        stock_id_in = 2'(id);
        order_ready = rdy;
        if (r) begin
            m_q.delete();
            for (int i = 0; i < 4; i++) begin
                m_pos[i]  = 0;
                m_last[i] = -1000;
            end
            m_drop = 0; m_conf = 0; m_buys = 0; m_sells = 0;
        end else begin
            pop      = (m_q.size() > 0) && rdy;
            was_full = (m_q.size() == DEPTH);
            cand     = 1'b0;
            is_sell  = 1'b0;
            if (sv && b && s) begin
                if (m_conf < 255) m_conf++;
            end else if (sv && (b || s) && (m_cyc >= m_last[id] + CD + 1)) begin
                is_sell = s;
                cand    = s ? (m_pos[id] > 0) : (m_pos[id] < MAX_POS);
            end
            if (pop) begin
                if (m_q[0] / 4 == 1) begin
                    if (m_sells < 65535) m_sells++;
                end else begin
                    if (m_buys < 65535) m_buys++;
                end
                void'(m_q.pop_front());
            end
            if (cand) begin
                if (!was_full || pop) begin
                    m_q.push_back(int'(is_sell) * 4 + id);
                    m_pos[id] += is_sell ? -1 : 1;
                    m_last[id] = m_cyc;
                end else if (m_drop < 255) begin
                    m_drop++;
                end
            end
        end
        m_cyc++;
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        m_cyc = 0;
        // Reset state
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        check("rst_valid", 32'(order_valid), 32'd0);
        check("rst_side",  32'(order_side), 32'd0);
        check("rst_stock", 32'(order_stock_id), 32'd0);
        check("rst_pos",   32'(positions), 32'd0);

        // Basic buy on stock 2: one-cycle order pulse
        step(0, 1, 1, 0, 2, 1);
        check("basic_valid", 32'(order_valid), 32'd1);
        check("basic_side",  32'(order_side), 32'd0);
        check("basic_stock", 32'(order_stock_id), 32'd2);
        check("basic_pos2",  32'(positions[11:8]), 32'd1);
        step(0, 0, 0, 0, 0, 1);
        check("basic_pulse", 32'(order_valid), 32'd0);

        // Sell guard: flat position cannot sell; after buy + cooldown it can
        step(1, 0, 0, 0, 0, 0);
        step(0, 1, 0, 1, 1, 1);
        check("sellguard_valid", 32'(order_valid), 32'd0);
        check("sellguard_pos",   32'(positions), 32'd0);
        step(0, 1, 1, 0, 1, 1);
        for (int i = 0; i < CD; i++) step(0, 0, 0, 0, 0, 1);
        step(0, 1, 0, 1, 1, 1);
        check("sell_valid", 32'(order_valid), 32'd1);
        check("sell_side",  32'(order_side), 32'd1);
        step(0, 0, 0, 0, 0, 1);
        check("sell_pos1", 32'(positions[7:4]), 32'd0);

        // Cooldown: buys at cycles 1..3 after the first are blocked, cycle 4 accepted
        step(1, 0, 0, 0, 0, 0);
        step(0, 1, 1, 0, 0, 1);
        step(0, 1, 1, 0, 0, 1);
        step(0, 1, 1, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        step(0, 1, 1, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        check("cooldown_pos0", 32'(positions[3:0]), 32'd2);

        // Backpressure: fill the FIFO, drop the fifth, then push+pop while full
        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 1, 0, i, 0);
        check("bp_full", 32'(fifo_full), 32'd1);
        step(0, 1, 1, 0, 0, 0);
        check("bp_drop", 32'(drop_count), 32'd1);
        check("bp_pos0", 32'(positions[3:0]), 32'd1);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        check("bp_stall_stock", 32'(order_stock_id), 32'd0);
        step(0, 1, 1, 0, 1, 1);
        check("pushpop_full", 32'(fifo_full), 32'd1);
        check("pushpop_pos1", 32'(positions[7:4]), 32'd2);
        check("pushpop_head", 32'(order_stock_id), 32'd1);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 1);
        check("drain_empty", 32'(order_valid), 32'd0);

        // Conflicting buy and sell
        step(0, 1, 1, 1, 2, 1);
        check("conflict_cnt",   32'(conflict_count), 32'd1);
        check("conflict_valid", 32'(order_valid), 32'd0);

        // Reset in the middle of a stalled handshake
        step(0, 1, 1, 0, 2, 0);
        step(0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        check("midrst_valid", 32'(order_valid), 32'd0);
        check("midrst_drop",  32'(drop_count), 32'd0);
        check("midrst_conf",  32'(conflict_count), 32'd0);

        // Position ceiling on stock 3
        step(0, 0, 0, 0, 0, 0);
        for (int n = 0; n < 16; n++) begin
            step(0, 1, 1, 0, 3, 1);
            for (int i = 0; i < CD; i++) step(0, 0, 0, 0, 0, 1);
        end
        check("maxpos_pos3", 32'(positions[15:12]), 32'd15);
`ifdef TRADE_STATS_EN
        check("maxpos_buys", 32'(buy_count), 32'd15);
`endif

        // Random traffic against the model
        step(1, 0, 0, 0, 0, 0);
        for (int n = 0; n < 1500; n++) begin
            step(($urandom_range(0, 299) == 0), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 int'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
